// File: rtl/mem_ctrl.sv
// Refill/writeback memory controller: serves cache refills from backing memory or from
// the dirty-eviction FIFO, and drains that FIFO to memory when no refill is pending.
//
// state | meaning
// IDLE  | arbitrate: forward hit, then refill read, then writeback drain
// RD    | mem_rd held until mem_ack or timeout
// WR    | mem_wr of FIFO head held until mem_ack or timeout
// RESP  | one-cycle ram_ready pulse with captured data
module mem_ctrl #(
    parameter int WB_DEPTH = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_req,
    input  logic [31:0] ram_address,
    output logic        ram_ready,
    output logic [63:0] ram_in,
    input  logic        wb_valid,
    input  logic [31:0] wb_address,
    input  logic [63:0] wb_data,
    output logic        wb_full,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err
);

    localparam int PW = $clog2(WB_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFF8;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t        state, state_nxt;
    logic [31:0]   fifo_addr [WB_DEPTH];
    logic [63:0]   fifo_data [WB_DEPTH];
    logic [PW-1:0] head, tail, fwd_idx;
    logic [PW:0]   count;
    logic [TW-1:0] tmo_cnt;
    logic          fwd_hit, push, pop, busy, tmo_hit;
    logic [63:0]   fwd_data, resp_data;

    assign wb_full = (count == (PW+1)'(WB_DEPTH));
    assign push    = wb_valid && !wb_full;
    assign busy    = (state == RD) || (state == WR);
    assign tmo_hit = busy && !mem_ack && (tmo_cnt == '0);

    // Scan oldest to youngest so the last match is the youngest entry.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            fwd_idx = head + PW'(i);
            if (i < int'(count) && ((fifo_addr[fwd_idx] ^ ram_address) & LINE_MASK) == '0) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_data[fwd_idx];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        resp_data = '0;
        case (state)
            IDLE: begin
                if (ram_req && fwd_hit) begin
                    state_nxt = RESP;
                    resp_data = fwd_data;
                end else if (ram_req) begin
                    state_nxt = RD;
                end else if (count != '0) begin
                    state_nxt = WR;
                end
            end
            RD: begin
                if (mem_ack) begin
                    state_nxt = RESP;
                    resp_data = mem_rdata;
                end else if (tmo_cnt == '0) begin
                    state_nxt = RESP;
                end
            end
            WR: begin
                if (mem_ack || tmo_cnt == '0) begin
                    state_nxt = IDLE;
                    pop       = 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ram_ready <= 1'b0;
            ram_in    <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            ram_ready <= (state_nxt == RESP);
            if (state_nxt == RESP)
                ram_in <= resp_data;

            if (state == IDLE && state_nxt == RD) begin
                mem_rd   <= 1'b1;
                mem_addr <= ram_address & LINE_MASK;
                tmo_cnt  <= TW'(TIMEOUT - 1);
            end
            if (state == IDLE && state_nxt == WR) begin
                mem_wr    <= 1'b1;
                mem_addr  <= fifo_addr[head] & LINE_MASK;
                mem_wdata <= fifo_data[head];
                tmo_cnt   <= TW'(TIMEOUT - 1);
            end
            if (busy) begin
                if (state_nxt != state) begin
                    mem_rd  <= 1'b0;
                    mem_wr  <= 1'b0;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt - 1'b1;
                end
            end
            if (tmo_hit)
                err <= 1'b1;

            // Full check is pre-pop, so a push against a full FIFO is dropped even on a pop.
            if (push)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[tail] <= wb_address;
            fifo_data[tail] <= wb_data;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus queues expected refills and memory commands,
// monitor/responder processes pop and compare when the DUT presents them.
module tb_mem_ctrl;

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } resp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [63:0] wdata;
        int          len;
    } memx_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ram_req = 1'b0;
    logic [31:0] ram_address = '0;
    logic        ram_ready;
    logic [63:0] ram_in;
    logic        wb_valid = 1'b0;
    logic [31:0] wb_address = '0;
    logic [63:0] wb_data = '0;
    logic        wb_full;
    logic [31:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        err;

    int          errors = 0;
    int          checks = 0;
    int          cyc_no = 0;
    int          cmd_cyc = 0;
    int          ack_lat = 1;
    logic        ack_en = 1'b1;
    logic [63:0] rd_val = '0;
    logic        rd_seen = 1'b0;
    int          rr_count = 0;

    resp_t exp_resp[$];
    memx_t exp_mem[$];

    mem_ctrl #(.WB_DEPTH(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .ram_req(ram_req), .ram_address(ram_address),
        .ram_ready(ram_ready), .ram_in(ram_in),
        .wb_valid(wb_valid), .wb_address(wb_address), .wb_data(wb_data), .wb_full(wb_full),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_no++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Refill monitor
    always @(negedge clk) begin
        resp_t r;
        if (rst) begin
            if (mem_rd) rd_seen = 1'b1;
            if (mem_rd || mem_wr) chk("mem_rd_wr_exclusive", 64'(mem_rd & mem_wr), 64'd0);
            if (ram_ready) begin
                rr_count++;
                if (exp_resp.size() == 0) begin
                    chk("unexpected_ram_ready", 64'd1, 64'd0);
                end else begin
                    r = exp_resp.pop_front();
                    chk("ram_in", ram_in, r.data);
                    chk("ram_ready_cycle", 64'(cyc_no), 64'(r.cyc));
                end
            end
        end
    end

    // Backing-memory responder; checks each command at its acknowledge.
    always @(negedge clk) begin
        memx_t m;
        if (!rst) begin
            cmd_cyc = 0;
            mem_ack = 1'b0;
        end else if (mem_rd || mem_wr) begin
            cmd_cyc++;
            if (ack_en && cmd_cyc >= ack_lat) begin
                mem_ack   = 1'b1;
                mem_rdata = rd_val;
                if (exp_mem.size() == 0) begin
                    chk("unexpected_mem_cmd", 64'd1, 64'd0);
                end else begin
                    m = exp_mem.pop_front();
                    chk("mem_is_wr", 64'(mem_wr), 64'(m.wr));
                    chk("mem_addr", 64'(mem_addr), 64'(m.addr));
                    if (m.wr) chk("mem_wdata", mem_wdata, m.wdata);
                    if (m.len > 0) chk("mem_cmd_cycles", 64'(cmd_cyc), 64'(m.len));
                end
            end else begin
                mem_ack = 1'b0;
            end
        end else begin
            cmd_cyc = 0;
            mem_ack = 1'b0;
        end
    end

    task automatic do_req(input logic [31:0] a, input logic [63:0] d, input int lat);
        int k = 0;
        exp_resp.push_back('{d, cyc_no + lat});
        ram_req     = 1'b1;
        ram_address = a;
        do begin
            @(negedge clk);
            k++;
        end while (!ram_ready && k < 50);
        chk("ram_ready_wait_expired", 64'(k >= 50), 64'd0);
        ram_req = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((exp_mem.size() != 0 || exp_resp.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_drain_expired"}, 64'(k >= 200), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int rc0;

        // Reset values
        @(negedge clk);
        chk("rst_ram_ready", 64'(ram_ready), 64'd0);
        chk("rst_ram_in", ram_in, 64'd0);
        chk("rst_mem_rd", 64'(mem_rd), 64'd0);
        chk("rst_mem_wr", 64'(mem_wr), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_wb_full", 64'(wb_full), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Refill miss, ack after 3 cycles
        ack_lat = 3;
        rd_val  = 64'hDEAD_BEEF_0000_0001;
        exp_mem.push_back('{1'b0, 32'h0000_1048, 64'd0, 3});
        do_req(32'h0000_1048, 64'hDEAD_BEEF_0000_0001, 4);
        wait_drain("miss");

        // Forward from writeback FIFO, then drain the entry
        ack_lat = 2;
        rd_seen = 1'b0;
        wb_valid = 1'b1; wb_address = 32'h0000_2000; wb_data = 64'h55;
        exp_mem.push_back('{1'b1, 32'h0000_2000, 64'h55, 0});
        @(negedge clk);
        wb_valid = 1'b0;
        do_req(32'h0000_2004, 64'h55, 1);
        wait_drain("forward");
        chk("forward_no_mem_rd", 64'(rd_seen), 64'd0);

        // Fill to full with acks withheld, drop fifth push, then drain in order
        ack_en  = 1'b0;
        ack_lat = 1;
        for (int i = 0; i < 4; i++) begin
            wb_valid   = 1'b1;
            wb_address = 32'h0000_3000 + 32'(8 * i);
            wb_data    = 64'hF000 + 64'(i);
            exp_mem.push_back('{1'b1, 32'h0000_3000 + 32'(8 * i), 64'hF000 + 64'(i), 0});
            @(negedge clk);
        end
        chk("wb_full_after_4_pushes", 64'(wb_full), 64'd1);
        wb_address = 32'h0000_3020; wb_data = 64'h99;
        @(negedge clk);
        wb_valid = 1'b0;
        chk("wb_full_after_dropped_push", 64'(wb_full), 64'd1);
        #1 ack_en = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (!mem_ack && k < 20);
        chk("first_ack_wait_expired", 64'(k >= 20), 64'd0);
        chk("wb_full_at_first_ack", 64'(wb_full), 64'd1);
        @(negedge clk);
        #1;
        chk("wb_full_after_first_ack", 64'(wb_full), 64'd0);
        wait_drain("fill");

        // Refill takes priority over two queued writebacks
        ack_lat = 2;
        rd_val  = 64'h1234_5678_9ABC_DEF0;
        wb_valid = 1'b1; wb_address = 32'h0000_4000; wb_data = 64'hA1;
        exp_mem.push_back('{1'b0, 32'h0000_5010, 64'd0, 2});
        exp_mem.push_back('{1'b1, 32'h0000_4000, 64'hA1, 0});
        exp_mem.push_back('{1'b1, 32'h0000_4008, 64'hB2, 0});
        @(negedge clk);
        wb_address = 32'h0000_4008; wb_data = 64'hB2;
        exp_resp.push_back('{64'h1234_5678_9ABC_DEF0, cyc_no + 3});
        ram_req = 1'b1; ram_address = 32'h0000_5010;
        @(negedge clk);
        wb_valid = 1'b0;
        k = 1;
        while (!ram_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("priority_ready_wait_expired", 64'(k >= 50), 64'd0);
        ram_req = 1'b0;
        wait_drain("priority");

        // Timeout on refill read
        ack_en = 1'b0;
        exp_resp.push_back('{64'd0, cyc_no + 9});
        ram_req = 1'b1; ram_address = 32'h0000_6000;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 8) chk("err_before_timeout", 64'(err), 64'd0);
            if (i == 9) begin
                chk("err_at_timeout", 64'(err), 64'd1);
                chk("ram_ready_at_timeout", 64'(ram_ready), 64'd1);
            end
        end
        ram_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("err_sticky", 64'(err), 64'd1);
        wait_drain("timeout");

        // Reset in the middle of a read
        ram_req = 1'b1; ram_address = 32'h0000_7000;
        repeat (3) @(negedge clk);
        rc0 = rr_count;
        #2 rst = 1'b0;
        #1;
        chk("midrst_mem_rd", 64'(mem_rd), 64'd0);
        chk("midrst_mem_addr", 64'(mem_addr), 64'd0);
        chk("midrst_mem_wdata", mem_wdata, 64'd0);
        chk("midrst_ram_ready", 64'(ram_ready), 64'd0);
        chk("midrst_ram_in", ram_in, 64'd0);
        chk("midrst_err", 64'(err), 64'd0);
        chk("midrst_wb_full", 64'(wb_full), 64'd0);
        ram_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_ram_ready_after_reset", 64'(rr_count - rc0), 64'd0);
        chk("no_mem_rd_after_reset", 64'(mem_rd), 64'd0);

        chk("resp_queue_empty", 64'(exp_resp.size()), 64'd0);
        chk("mem_queue_empty", 64'(exp_mem.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
